// File: rtl/wb_backdoor_arbiter.sv
// Two-master round-robin arbiter for the wb_system backdoor Wishbone slave port.
// A grant is held for a whole bus cycle; unanswered strobes end with a one-cycle err pulse.
module wb_backdoor_arbiter #(
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_data_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_cyc_i,
  input  logic        m0_strobe_i,
  input  logic        m0_we_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_data_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_cyc_i,
  input  logic        m1_strobe_i,
  input  logic        m1_we_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_data_o,
  output logic [31:0] s_addr_o,
  output logic        s_cyc_o,
  output logic        s_strobe_o,
  output logic        s_we_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TCNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_reg, state_next;
  logic                     last_gnt_reg, last_gnt_next;
  logic [TIMEOUT_WIDTH-1:0] tcnt_reg, tcnt_next;

  logic [1:0]  cyc, stb, we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  ack, err;
  logic [31:0] rdata [2];

  logic sel, granted, own_cyc, own_stb, live, terminal;

  assign cyc      = {m1_cyc_i, m0_cyc_i};
  assign stb      = {m1_strobe_i, m0_strobe_i};
  assign we       = {m1_we_i, m0_we_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign wdata[0] = m0_data_i;
  assign wdata[1] = m1_data_i;

  // Outputs are forced quiet while reset is high so a mid-cycle reset is seen immediately.
  assign sel      = (state_reg == GNT1);
  assign granted  = (state_reg != IDLE) && !reset;
  assign own_cyc  = cyc[sel];
  assign own_stb  = stb[sel];
  assign live     = granted && own_cyc;
  assign terminal = live && own_stb && !s_ack_i && (tcnt_reg == TCNT_LAST);

  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    tcnt_next     = '0;
    case (state_reg)
      IDLE: begin
        if (cyc[0] && cyc[1]) state_next = last_gnt_reg ? GNT0 : GNT1;
        else if (cyc[0])      state_next = GNT0;
        else if (cyc[1])      state_next = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_next    = IDLE;
          last_gnt_next = sel;
        end else if (own_stb && !s_ack_i && (tcnt_reg != TCNT_LAST)) begin
          // The terminal count falls through to zero, so the counter can never wrap.
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      tcnt_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      tcnt_reg     <= tcnt_next;
    end
  end

  assign s_cyc_o    = granted && own_cyc;
  assign s_strobe_o = granted && own_stb;
  assign s_we_o     = granted && we[sel];
  assign s_addr_o   = granted ? addr[sel]  : '0;
  assign s_data_o   = granted ? wdata[sel] : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic mine;
      assign mine      = live && (sel == 1'(gi));
      assign ack[gi]   = mine && s_ack_i;
      assign err[gi]   = terminal && (sel == 1'(gi));
      assign rdata[gi] = mine ? s_data_i : '0;
    end
  endgenerate

  assign m0_ack_o  = ack[0];
  assign m0_err_o  = err[0];
  assign m0_data_o = rdata[0];
  assign m1_ack_o  = ack[1];
  assign m1_err_o  = err[1];
  assign m1_data_o = rdata[1];

endmodule

// File: tb/tb_wb_backdoor_arbiter.sv
// Bench for wb_backdoor_arbiter: directed scenarios with literal expectations, then
// randomized traffic, every cycle compared against an ownership-level reference model.
module tb_wb_backdoor_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_data_i = '0, m0_addr_i = '0;
  logic        m0_cyc_i = 1'b0, m0_strobe_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m1_data_i = '0, m1_addr_i = '0;
  logic        m1_cyc_i = 1'b0, m1_strobe_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] s_data_o, s_addr_o;
  logic        s_cyc_o, s_strobe_o, s_we_o;
  logic [31:0] s_data_i = '0;
  logic        s_ack_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  wb_backdoor_arbiter #(.TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .m0_data_i(m0_data_i), .m0_addr_i(m0_addr_i), .m0_cyc_i(m0_cyc_i),
    .m0_strobe_i(m0_strobe_i), .m0_we_i(m0_we_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_data_i(m1_data_i), .m1_addr_i(m1_addr_i), .m1_cyc_i(m1_cyc_i),
    .m1_strobe_i(m1_strobe_i), .m1_we_i(m1_we_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_data_o(s_data_o), .s_addr_o(s_addr_o), .s_cyc_o(s_cyc_o),
    .s_strobe_o(s_strobe_o), .s_we_o(s_we_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who owned it last,
  // and how many strobe cycles in a row went unanswered.
  int owner = 0;
  int prev_winner = 2;
  int unanswered = 0;

  function automatic logic own_bit(input logic b0, input logic b1);
    return (owner == 1) ? b0 : (owner == 2) ? b1 : 1'b0;
  endfunction

  function automatic logic [31:0] exp_slave(input logic [31:0] v0, input logic [31:0] v1);
    if (reset || owner == 0) return '0;
    return (owner == 1) ? v0 : v1;
  endfunction

  function automatic logic talking_to(input int n);
    return !reset && owner == n && own_bit(m0_cyc_i, m1_cyc_i);
  endfunction

  function automatic logic exp_err(input int n);
    return talking_to(n) && own_bit(m0_strobe_i, m1_strobe_i) && !s_ack_i && unanswered == TO - 1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      owner <= 0; prev_winner <= 2; unanswered <= 0;
    end else if (owner == 0) begin
      unanswered <= 0;
      if (m0_cyc_i && m1_cyc_i) owner <= (prev_winner == 1) ? 2 : 1;
      else if (m0_cyc_i)        owner <= 1;
      else if (m1_cyc_i)        owner <= 2;
    end else if (!own_bit(m0_cyc_i, m1_cyc_i)) begin
      prev_winner <= owner; owner <= 0; unanswered <= 0;
    end else if (own_bit(m0_strobe_i, m1_strobe_i) && !s_ack_i) begin
      unanswered <= (unanswered == TO - 1) ? 0 : unanswered + 1;
    end else begin
      unanswered <= 0;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("s_cyc",    32'(s_cyc_o),    32'(exp_slave(32'(m0_cyc_i), 32'(m1_cyc_i))));
      check("s_strobe", 32'(s_strobe_o), 32'(exp_slave(32'(m0_strobe_i), 32'(m1_strobe_i))));
      check("s_we",     32'(s_we_o),     32'(exp_slave(32'(m0_we_i), 32'(m1_we_i))));
      check("s_addr",   s_addr_o,        exp_slave(m0_addr_i, m1_addr_i));
      check("s_data",   s_data_o,        exp_slave(m0_data_i, m1_data_i));
      check("m0_ack",   32'(m0_ack_o),   32'(talking_to(1) && s_ack_i));
      check("m1_ack",   32'(m1_ack_o),   32'(talking_to(2) && s_ack_i));
      check("m0_data",  m0_data_o,       talking_to(1) ? s_data_i : 32'h0);
      check("m1_data",  m1_data_o,       talking_to(2) ? s_data_i : 32'h0);
      check("m0_err",   32'(m0_err_o),   32'(exp_err(1)));
      check("m1_err",   32'(m1_err_o),   32'(exp_err(2)));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drop_all();
    m0_cyc_i = 0; m0_strobe_i = 0; m0_we_i = 0;
    m1_cyc_i = 0; m1_strobe_i = 0; m1_we_i = 0;
    s_ack_i = 0;
  endtask

  initial begin
    int g, w;
    // Reset with both masters requesting
    m0_addr_i = 32'h100; m1_addr_i = 32'h200;
    m0_cyc_i = 1; m1_cyc_i = 1; m0_strobe_i = 1; m1_strobe_i = 1;
    s_ack_i = 1; s_data_i = 32'h55AA55AA;
    tick();
    checking = 1'b1;
    check("rst_s_cyc", 32'(s_cyc_o), 0);
    check("rst_m0_ack", 32'(m0_ack_o), 0);
    check("rst_m0_data", m0_data_o, 0);
    tick(); tick();
    reset = 0; s_ack_i = 0;
    #1 check("post_rst_idle", 32'(s_cyc_o), 0);
    tick();
    check("first_gnt_cyc", 32'(s_cyc_o), 1);
    check("first_gnt_addr", s_addr_o, 32'h100);
    drop_all(); tick(); tick(); tick();

    // Single master m1 write
    m1_cyc_i = 1; m1_strobe_i = 1; m1_we_i = 1;
    m1_addr_i = 32'h4; m1_data_i = 32'hDEADBEEF;
    tick();
    check("single_addr", s_addr_o, 32'h4);
    check("single_wdata", s_data_o, 32'hDEADBEEF);
    check("single_we", 32'(s_we_o), 1);
    check("single_noack", 32'(m1_ack_o), 0);
    s_ack_i = 1; s_data_i = 32'hCAFEF00D;
    #1;
    check("single_m1_ack", 32'(m1_ack_o), 1);
    check("single_m1_data", m1_data_o, 32'hCAFEF00D);
    check("single_m0_ack", 32'(m0_ack_o), 0);
    check("single_m0_data", m0_data_o, 0);
    tick(); drop_all(); tick(); tick();

    // Contention: both request continuously, each releases after one acked beat
    m0_addr_i = 32'h100; m1_addr_i = 32'h200; m1_we_i = 0;
    m0_cyc_i = 1; m0_strobe_i = 1; m1_cyc_i = 1; m1_strobe_i = 1;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (!s_cyc_o && w < 10) begin tick(); w++; end
      if (!s_cyc_o) begin
        n_cmp++; n_bad++;
        $display("FAIL contention_wait: no grant within 10 cycles (transaction %0d)", t);
      end
      g = (s_addr_o == 32'h200) ? 1 : 0;
      check($sformatf("grant_order%0d", t), 32'(g), 32'(t % 2));
      check($sformatf("idle_gap%0d", t), 32'(w), 32'(t == 0 ? 1 : 1));
      s_ack_i = 1; tick(); s_ack_i = 0;
      if (g == 0) begin m0_cyc_i = 0; m0_strobe_i = 0; end
      else begin m1_cyc_i = 0; m1_strobe_i = 0; end
      tick();
      if (g == 0) begin m0_cyc_i = 1; m0_strobe_i = 1; end
      else begin m1_cyc_i = 1; m1_strobe_i = 1; end
    end
    drop_all(); tick(); tick(); tick();

    // Hold: m1 requests mid-way through a 3-beat m0 cycle
    m0_cyc_i = 1; m0_strobe_i = 1;
    tick();
    s_ack_i = 1;
    for (int b = 0; b < 3; b++) begin
      if (b == 1) m1_cyc_i = 1;
      #1;
      check($sformatf("hold_addr%0d", b), s_addr_o, 32'h100);
      check($sformatf("hold_m1_ack%0d", b), 32'(m1_ack_o), 0);
      tick();
    end
    m0_cyc_i = 0; m0_strobe_i = 0; s_ack_i = 0;
    #1 check("hold_release", 32'(s_cyc_o), 0);
    tick();
    check("hold_idle", 32'(s_cyc_o), 0);
    tick();
    check("hold_m1_cyc", 32'(s_cyc_o), 1);
    check("hold_m1_addr", s_addr_o, 32'h200);
    drop_all(); tick(); tick();

    // Timeout on an unacknowledged address
    m0_cyc_i = 1; m0_strobe_i = 1; m0_addr_i = 32'hBAD0;
    tick();
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("to_err%0d", k), 32'(m0_err_o), 32'(k == 4));
      check($sformatf("to_ack%0d", k), 32'(m0_ack_o), 0);
      tick();
    end
    s_ack_i = 1;
    #1;
    check("to_term_ack", 32'(m0_ack_o), 1);
    check("to_term_err", 32'(m0_err_o), 0);
    tick(); drop_all(); tick(); tick();

    // Reset in the middle of a GNT1 strobe
    m0_addr_i = 32'h100;
    m1_cyc_i = 1; m1_strobe_i = 1; s_ack_i = 1;
    tick();
    check("mid_pre_ack", 32'(m1_ack_o), 1);
    m0_cyc_i = 1; reset = 1;
    tick();
    check("mid_s_cyc", 32'(s_cyc_o), 0);
    check("mid_m1_ack", 32'(m1_ack_o), 0);
    tick();
    reset = 0;
    #1 check("mid_idle", 32'(s_cyc_o), 0);
    tick();
    check("mid_m0_first", s_addr_o, 32'h100);
    drop_all(); tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) < 2) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 9) < 2) m1_cyc_i = ~m1_cyc_i;
      m0_strobe_i = ($urandom_range(0, 3) != 0);
      m1_strobe_i = ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_data_i = $urandom; m1_data_i = $urandom;
      s_data_i = $urandom;
      s_ack_i = ($urandom_range(0, 99) < ((c < 2000) ? 30 : 8));
      reset = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 0; drop_all(); tick();
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
